// File: rtl/mem_wb_skid_stage.sv
// MEM->WB two-entry skid stage: valid/ready handshake, flush bubble, falling-edge state.
// Optional backpressure counter enabled by defining PIPE_STAGE_PERF_EN.
module mem_wb_skid_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 3,
    parameter int CTRL_W   = 2,
    parameter int REG_W    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [REG_W-1:0]           in_wreg,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [REG_W-1:0]           out_wreg,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [1:0]                 occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]                perf_bp_cnt
`endif
);

    localparam int PW = NUM_DATA * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [REG_W-1:0]  main_wreg, skid_wreg;
    logic [PW-1:0]     main_data, skid_data;

    logic in_xfer, out_xfer;
    logic load_main, main_from_skid, load_skid;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        load_main = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer) begin
                        load_skid = 1'b1;
                        state_nxt = FULL;
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_from_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // ready comes only from registered state, flush and reset, never out_ready
    always_comb begin
        in_ready  = (state != FULL) & ~flush & reset;
        out_valid = (state != EMPTY);
        occupancy = state;
        out_ctrl  = out_valid ? main_ctrl : '0;
        out_wreg  = main_wreg;
        out_data  = main_data;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            main_ctrl <= '0;
            main_wreg <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_wreg <= '0;
            skid_data <= '0;
        end else begin
            if (flush) begin
                main_ctrl <= '0;
            end else if (load_main) begin
                main_ctrl <= in_ctrl;
                main_wreg <= in_wreg;
                main_data <= in_data;
            end else if (main_from_skid) begin
                main_ctrl <= skid_ctrl;
                main_wreg <= skid_wreg;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_wreg <= in_wreg;
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // saturating; flush deliberately leaves it alone
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            perf_bp_cnt <= '0;
        end else if (out_valid && !out_ready && perf_bp_cnt != 16'hFFFF) begin
            perf_bp_cnt <= perf_bp_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: directed steps plus random traffic
// against a queue-based reference model.
module tb_mem_wb_skid_stage;

    localparam int DW = 32;
    localparam int ND = 3;
    localparam int CW = 2;
    localparam int RW = 5;
    localparam int PW = DW * ND;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [RW-1:0] w;
        logic [PW-1:0] d;
    } word_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [RW-1:0] in_wreg;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [RW-1:0] out_wreg;
    logic [PW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]   perf_bp_cnt;
`endif

    word_t q[$];
    int    tests = 0;
    int    fails = 0;
    int    exp_cnt = 0;

    always #5 clk = ~clk;

    mem_wb_skid_stage #(
        .DATA_W(DW), .NUM_DATA(ND), .CTRL_W(CW), .REG_W(RW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ctrl(in_ctrl),
        .in_wreg(in_wreg),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl(out_ctrl),
        .out_wreg(out_wreg),
        .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_bp_cnt(perf_bp_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [PW-1:0] obs,
                       input logic [PW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t mk(input logic [CW-1:0] c,
                                 input logic [RW-1:0] w,
                                 input logic [PW-1:0] d);
        word_t r;
        r.c = c;
        r.w = w;
        r.d = d;
        return r;
    endfunction

    function automatic word_t rnd_word();
        return mk(CW'($urandom), RW'($urandom),
                  {$urandom, $urandom, $urandom});
    endfunction

    task automatic check_outputs();
        logic er;
        er = reset && !flush && (q.size() < 2);
        chk("in_ready", PW'(in_ready), PW'(er));
        chk("out_valid", PW'(out_valid), PW'(q.size() > 0));
        chk("occupancy", PW'(occupancy), PW'(q.size()));
        if (q.size() > 0) begin
            chk("out_ctrl", PW'(out_ctrl), PW'(q[0].c));
            chk("out_wreg", PW'(out_wreg), PW'(q[0].w));
            chk("out_data", out_data, q[0].d);
        end else begin
            chk("out_ctrl_bubble", PW'(out_ctrl), '0);
        end
`ifdef PIPE_STAGE_PERF_EN
        chk("perf_bp_cnt", PW'(perf_bp_cnt), PW'(exp_cnt));
`endif
    endtask

    task automatic check_reset();
        chk("rst_in_ready", PW'(in_ready), '0);
        chk("rst_out_valid", PW'(out_valid), '0);
        chk("rst_out_ctrl", PW'(out_ctrl), '0);
        chk("rst_out_wreg", PW'(out_wreg), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_occupancy", PW'(occupancy), '0);
`ifdef PIPE_STAGE_PERF_EN
        chk("rst_perf", PW'(perf_bp_cnt), '0);
`endif
    endtask

    // drive one cycle, check, then advance the model across the falling edge
    task automatic cycle(input logic iv, input logic orr, input logic fl,
                         input word_t w);
        logic ix, ox;
        @(posedge clk);
        in_valid  = iv;
        out_ready = orr;
        flush     = fl;
        in_ctrl   = w.c;
        in_wreg   = w.w;
        in_data   = w.d;
        #1;
        check_outputs();
        ix = iv && reset && !fl && (q.size() < 2);
        ox = orr && (q.size() > 0);
        @(negedge clk);
        if (q.size() > 0 && !orr && exp_cnt < 65535) exp_cnt++;
        if (fl) begin
            q.delete();
        end else begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(w);
        end
    endtask

    task automatic async_reset_pulse();
        @(posedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset();
        q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rel_in_ready", PW'(in_ready), PW'(1'b1));
    endtask

    initial begin
        word_t w;
        logic [PW-1:0] d;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_wreg   = '0;
        in_data   = '0;
        #2 reset = 1'b0;
        #6 check_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rel_in_ready", PW'(in_ready), PW'(1'b1));

        for (int i = 3; i <= 7; i++) begin
            for (int k = 0; k < ND; k++) d[k*DW +: DW] = 32'h1000 + k;
            cycle(1'b1, 1'b1, 1'b0, mk(2'b01, RW'(i), d));
            chk("stream_occ_le1", PW'(occupancy <= 2'd1), PW'(1'b1));
        end
        cycle(1'b0, 1'b1, 1'b0, rnd_word());
        cycle(1'b0, 1'b1, 1'b0, rnd_word());

        cycle(1'b1, 1'b0, 1'b0, mk(2'b01, 5'd8, {3{32'h0000_0008}}));
        cycle(1'b1, 1'b0, 1'b0, mk(2'b11, 5'd9, {3{32'h0000_0009}}));
        cycle(1'b1, 1'b0, 1'b0, mk(2'b01, 5'd10, {3{32'h0000_000A}}));
        cycle(1'b0, 1'b1, 1'b0, rnd_word());
        cycle(1'b0, 1'b1, 1'b0, rnd_word());
        cycle(1'b0, 1'b1, 1'b0, rnd_word());

        cycle(1'b1, 1'b0, 1'b0, rnd_word());
        cycle(1'b1, 1'b0, 1'b0, rnd_word());
        cycle(1'b1, 1'b0, 1'b1, mk(2'b01, 5'd10, {3{32'h0000_000A}}));
        cycle(1'b0, 1'b1, 1'b0, rnd_word());
        cycle(1'b0, 1'b1, 1'b0, rnd_word());

        cycle(1'b1, 1'b0, 1'b0, rnd_word());
        cycle(1'b1, 1'b0, 1'b0, rnd_word());
        async_reset_pulse();
        cycle(1'b1, 1'b0, 1'b0, mk(2'b01, 5'd1, {3{32'hDEADBEEF}}));
        cycle(1'b0, 1'b1, 1'b0, rnd_word());
        cycle(1'b0, 1'b1, 1'b0, rnd_word());

        for (int n = 0; n < 10000; n++) begin
            w = rnd_word();
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 63) == 0), w);
        end

`ifdef PIPE_STAGE_PERF_EN
        cycle(1'b0, 1'b1, 1'b1, rnd_word());
        cycle(1'b1, 1'b0, 1'b0, rnd_word());
        for (int n = 0; n < 70000; n++) cycle(1'b0, 1'b0, 1'b0, rnd_word());
        #1 chk("perf_saturated", PW'(perf_bp_cnt), PW'(16'hFFFF));
        cycle(1'b0, 1'b0, 1'b1, rnd_word());
        cycle(1'b0, 1'b1, 1'b0, rnd_word());
        #1 chk("perf_after_flush", PW'(perf_bp_cnt), PW'(16'hFFFF));
        async_reset_pulse();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
